uart_tx_buffered: RTL

//   Buffered UART transmitter; the transmit-side counterpart of the serial-bus UART receiver.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_buffered_if.sv | 16 +
 rtl/uart_tx_fifo.sv | 53 +++++
 rtl/uart_tx_buffered.sv | 134 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings, default frame geometry and line levels.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int DEF_CLOCKS_PER_PULSE = 16;
    localparam int DEF_DATA_WIDTH       = 8;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Parallel write port and serial/status outputs of the buffered UART transmitter.
interface uart_tx_buffered_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_en;
    logic                  full;
    logic                  overflow;
    logic                  busy;
    logic                  tx;

    modport master (output data_in, data_en, input full, overflow, busy, tx);
    modport slave  (input data_in, data_en, output full, overflow, busy, tx);
endinterface

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO feeding the transmitter; head word is visible combinationally.
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_WIDTH-1:0]         din,
    output logic [DATA_WIDTH-1:0]         dout,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    // full comes from the registered count, so a same-edge pop never frees a slot for a write
    assign full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end
endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed 8N1-style serialiser with contiguous back-to-back frames.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = DEF_CLOCKS_PER_PULSE,
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic               clk,
    input  logic               rstn,
    uart_tx_buffered_if.slave  bus
);
    localparam int CNT_W = $clog2(CLOCKS_PER_PULSE);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CLK_LAST = CNT_W'(CLOCKS_PER_PULSE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    uart_state_e           r_state, w_state_nxt;
    logic                  r_tx, w_tx_nxt;
    logic [CNT_W-1:0]      r_clk_cnt, w_clk_cnt_nxt;
    logic [BIT_W-1:0]      r_bit_cnt, w_bit_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
    logic                  r_overflow;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_fifo_dout;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] w_fifo_count;

    uart_tx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (bus.data_en),
        .pop   (w_pop),
        .din   (bus.data_in),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_tx_nxt      = r_tx;
        w_clk_cnt_nxt = r_clk_cnt + 1'b1;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_pop         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tx_nxt      = STOP_BIT;
                w_clk_cnt_nxt = '0;
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_fifo_dout;
                    w_tx_nxt    = START_BIT;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (r_clk_cnt == CLK_LAST) begin
                    w_clk_cnt_nxt = '0;
                    w_bit_cnt_nxt = '0;
                    w_tx_nxt      = r_shift[0];
                    w_state_nxt   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_clk_cnt == CLK_LAST) begin
                    w_clk_cnt_nxt = '0;
                    if (r_bit_cnt == BIT_LAST) begin
                        w_tx_nxt    = STOP_BIT;
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_shift_nxt   = r_shift >> 1;
                        w_tx_nxt      = w_shift_nxt[0];
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (r_clk_cnt == CLK_LAST) begin
                    w_clk_cnt_nxt = '0;
                    // chain straight into the next start bit when more words are waiting
                    if (!w_fifo_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_fifo_dout;
                        w_tx_nxt    = START_BIT;
                        w_state_nxt = ST_START;
                    end else begin
                        w_tx_nxt    = STOP_BIT;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_tx_nxt      = STOP_BIT;
                w_clk_cnt_nxt = '0;
                w_state_nxt   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tx       <= STOP_BIT;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_tx       <= w_tx_nxt;
            r_clk_cnt  <= w_clk_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_overflow <= bus.data_en & w_fifo_full;
        end
    end

    always_ff @(posedge clk) begin
        r_shift <= w_shift_nxt;
    end

    assign bus.tx       = r_tx;
    assign bus.full     = w_fifo_full;
    assign bus.overflow = r_overflow;
    assign bus.busy     = (r_state != ST_IDLE) | (w_fifo_count != '0);
endmodule
